dpwm_dt_core: RTL
=================

// Module: dpwm_dt_core
// PURPOSE
//  Parametrised complementary DPWM with per-edge dead-time insertion, double-buffered settings and a sticky fault trip.
//  Drives one high-side/low-side gate pair of the power converter directly from the FPGA clock.
//  Sits between the control loop, which supplies period, duty and dead-time as cycle counts, and the GPIO gate pins.
// PARAMETERS
//  CNT_W      10  width of counter, period and duty (clk cycles)
//  DT_W        3  width of dead-time values (clk cycles)
//  MIN_PERIOD  8  smallest accepted period_i; smaller values are clamped up to this
// PORTS
//  clk           in   1      system clock, single clock domain
//  resetn        in   1      asynchronous active-low reset
//  en_i          in   1      run enable
//  period_i      in   CNT_W  last counter value; the PWM period is period_i+1 cycles
//  duty_i        in   CNT_W  high-side request length in cycles
//  dt_h_i        in   DT_W   dead time before hs_o turns on
//  dt_l_i        in   DT_W   dead time before ls_o turns on
//  fault_i       in   1      synchronous trip request
//  fault_clr_i   in   1      clears the latched fault
//  hs_o          out  1      high-side gate drive (was C_1)
//  ls_o          out  1      low-side gate drive (was C_2)
//  pstart_o      out  1      1-cycle pulse on every cycle with cnt==0 while running
//  fault_o       out  1      latched fault status
// BEHAVIOUR
//  Reset: cnt=0, all shadow registers 0, hs_o=ls_o=pstart_o=fault_o=0, both dead-time counters 0.
//  run = en_i & ~fault_o.
//  Counter: while run, cnt counts 0..per_sh and wraps to 0. While not run, cnt is held at 0.
//  Shadows (per_sh, duty_sh, dth_sh, dtl_sh) load from the inputs:
//   - when run & cnt==per_sh (last cycle of the period), or
//   - on every cycle with run low.
//   Mid-period input changes therefore take effect at the next cnt==0.
//  Clamps, applied at shadow load:
//   - per_sh = max(period_i, MIN_PERIOD).
//   - duty_sh = min(duty_i, per_sh+1). duty_sh = per_sh+1 gives a permanent high-side request.
//  Requests (combinational): hreq = run & (cnt < duty_sh); lreq = run & ~hreq.
//  Dead-time gate, per channel (h shown; l is identical using lreq and dtl_sh):
//   - hreq low: dcnt_h <= 0, hs_o <= 0 (turn-off after 1 clk, no dead time).
//   - hreq high & dcnt_h < dth_sh: dcnt_h <= dcnt_h+1, hs_o <= 0.
//   - hreq high & dcnt_h == dth_sh: hs_o <= 1.
//   - Turn-on latency is dt+1 clocks after the request rises; the high pulse is duty_sh-dth_sh cycles,
//     or 0 if duty_sh <= dth_sh.
//  Invariant: hs_o & ls_o == 0 on every cycle, for every input sequence.
//  pstart_o is registered: it is high on the cycle after cnt==0 is evaluated with run high.
//  Fault:
//   - fault_i high at a posedge sets fault_o; hs_o, ls_o and pstart_o go to 0 on that edge.
//   - fault_o clears only when fault_clr_i=1 and fault_i=0 on the same edge; fault_i wins if both are high.
//   - After clearing, the block restarts from cnt=0 with freshly loaded shadows; both channels wait their full dead time.
//  en_i falling: both outputs go to 0 on the next edge and cnt returns to 0. There is no finishing of the current period.
//  Async reset mid-period: outputs drop immediately (asynchronously). After release, behaviour is as on a fresh enable.
// STRUCTURE
//  Package dpwm_pkg holds CNT_W/DT_W defaults, MIN_PERIOD, and the cnt_t/dt_t typedefs shared with the controller.
//  Sub-module dpwm_dt_gate holds one dead-time counter plus its output register. It is instantiated twice (h, l).
//  Top level holds the counter, shadow registers, clamps, fault latch and pstart generation.
// TESTING
//  1. period=249, duty=150, dt_h=2, dt_l=3, en=1
//     -> 250-cycle period; hs_o high 148 and ls_o high 97 cycles each period; hs_o&ls_o never 1.
//  2. duty changed 150->100 at cnt=40
//     -> current period keeps 148-cycle hs_o; the next period, after pstart_o, shows 98.
//  3. duty=0 -> hs_o stays 0 and ls_o stays high continuously.
//     duty=400 with period=249 -> clamped to 250; hs_o stays high continuously and ls_o stays 0.
//  4. period=3 -> clamped to MIN_PERIOD; pstart_o pulses every 9 cycles.
//  5. fault_i pulse at cnt=60 -> next edge hs_o=ls_o=0 and fault_o=1, held until fault_clr_i;
//     after the clear, pstart_o fires and the first hs_o rise comes 3 clk after that (dt_h=2).
//  6. resetn low at cnt=120 for 2 cycles -> outputs 0 immediately; after release, the scenario 1 waveform resumes from cnt=0.

Source files
------------

// File: rtl/dpwm_pkg.sv
// Shared defaults and typedefs for the dead-time DPWM core and its controller.
package dpwm_pkg;

    localparam int unsigned CNT_W_DEF      = 10;
    localparam int unsigned DT_W_DEF       = 3;
    localparam int unsigned MIN_PERIOD_DEF = 8;

    typedef logic [CNT_W_DEF-1:0] cnt_t;
    typedef logic [DT_W_DEF-1:0]  dt_t;

endpackage

// File: rtl/dpwm_dt_gate.sv
// One gate channel: holds the output low for dt_i cycles after the request rises,
// and drops it on the first edge after the request falls.
module dpwm_dt_gate import dpwm_pkg::*; #(
    parameter int unsigned DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_i,
    input  logic [DT_W-1:0] dt_i,
    output logic            out_o
);

    logic [DT_W-1:0] dcnt_q;

    // '>=' rather than '==' so a shorter dead time loaded mid-request cannot stall the count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dcnt_q <= '0;
            out_o  <= 1'b0;
        end else if (!req_i) begin
            dcnt_q <= '0;
            out_o  <= 1'b0;
        end else if (dcnt_q < dt_i) begin
            dcnt_q <= dcnt_q + DT_W'(1);
            out_o  <= 1'b0;
        end else begin
            out_o  <= 1'b1;
        end
    end

endmodule

// File: rtl/dpwm_dt_core.sv
// Complementary DPWM: period counter, double-buffered settings with clamps,
// sticky fault trip and per-edge dead-time insertion on the hs/ls gate pair.
module dpwm_dt_core import dpwm_pkg::*; #(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DT_W       = DT_W_DEF,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic [DT_W-1:0]  dt_h_i,
    input  logic [DT_W-1:0]  dt_l_i,
    input  logic             fault_i,
    input  logic             fault_clr_i,
    output logic             hs_o,
    output logic             ls_o,
    output logic             pstart_o,
    output logic             fault_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W:0]   duty_sh_q, duty_sh_d, per_p1;
    logic [DT_W-1:0]  dth_sh_q, dtl_sh_q;
    logic             fault_q, pstart_q;
    logic             run, active, last, load, hreq, lreq;

    // duty_sh is one bit wider so a full-period request (per_sh+1) fits at any period
    always_comb begin
        run       = en_i & ~fault_q;
        active    = run & ~fault_i;
        last      = (cnt_q == per_sh_q);
        load      = ~run | last;
        per_sh_d  = (period_i < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_i;
        per_p1    = {1'b0, per_sh_d} + (CNT_W+1)'(1);
        duty_sh_d = ({1'b0, duty_i} > per_p1) ? per_p1 : {1'b0, duty_i};
        cnt_d     = (!active || last) ? '0 : cnt_q + CNT_W'(1);
        hreq      = run & ({1'b0, cnt_q} < duty_sh_q);
        lreq      = run & ~hreq;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            per_sh_q  <= '0;
            duty_sh_q <= '0;
            dth_sh_q  <= '0;
            dtl_sh_q  <= '0;
            fault_q   <= 1'b0;
            pstart_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pstart_q <= active & (cnt_q == '0);
            fault_q  <= fault_i | (fault_q & ~fault_clr_i);
            if (load) begin
                per_sh_q  <= per_sh_d;
                duty_sh_q <= duty_sh_d;
                dth_sh_q  <= dt_h_i;
                dtl_sh_q  <= dt_l_i;
            end
        end
    end

    // fault_i masks the requests so both gates drop on the very edge that latches the trip
    dpwm_dt_gate #(.DT_W(DT_W)) u_gate_h (
        .clk    (clk),
        .resetn (resetn),
        .req_i  (hreq & ~fault_i),
        .dt_i   (dth_sh_q),
        .out_o  (hs_o)
    );

    dpwm_dt_gate #(.DT_W(DT_W)) u_gate_l (
        .clk    (clk),
        .resetn (resetn),
        .req_i  (lreq & ~fault_i),
        .dt_i   (dtl_sh_q),
        .out_o  (ls_o)
    );

    assign pstart_o = pstart_q;
    assign fault_o  = fault_q;

endmodule
